// File: rtl/lfsr_pkg.sv
// Shared types, default constants and the single-step Galois function
// used by the LFSR pattern generator and its combinational stepper.
package lfsr_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } lfsr_state_e;

    localparam logic [15:0] LFSR16_TAPS = 16'h0006;
    localparam logic [15:0] LFSR16_SEED = 16'hA2C1;

    // One Galois step on a register of 'width' bits held in the low bits
    // of r (upper bits zero). Bit width-1 takes r[0]; lower bits shift
    // down and pick up the feedback where the tap mask is set.
    function automatic logic [31:0] lfsr_step(
        input logic [31:0] r,
        input logic [31:0] taps,
        input int          width
    );
        logic [31:0] top;
        logic [31:0] nxt;
        top = 32'd1 << (width - 1);
        nxt = r >> 1;
        if (r[0]) begin
            nxt = (nxt ^ (taps & ~top)) | top;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_galois_stepper.sv
// Combinational OUT_BITS-deep unroll of the Galois step.
// Ports: r (current reg), r_next (OUT_BITS steps ahead), data (bit 0 oldest).
module lfsr_galois_stepper
    import lfsr_pkg::*;
#(
    parameter int             WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR16_TAPS),
    parameter int             OUT_BITS = 1
) (
    input  logic [WIDTH-1:0]    r,
    output logic [WIDTH-1:0]    r_next,
    output logic [OUT_BITS-1:0] data
);

    logic [WIDTH-1:0] chain [OUT_BITS+1];

    assign chain[0] = r;

    for (genvar k = 0; k < OUT_BITS; k++) begin : g_step
        assign chain[k+1] = WIDTH'(lfsr_step(32'(chain[k]), 32'(TAPS), WIDTH));
        assign data[k]    = chain[k][0];
    end

    assign r_next = chain[OUT_BITS];

endmodule

// File: rtl/lfsr_galois_gen.sv
// Galois LFSR pattern generator with seed load, lockup guard, burst counter
// and a valid/ready output stream. Ports: control (seed_load/seed_val,
// start/burst_len, abort), stream (out_valid/out_ready/out_data), status
// (busy, done, lockup, state_out).
module lfsr_galois_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR16_TAPS),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(LFSR16_SEED),
    parameter int               OUT_BITS = 1,
    parameter int               LEN_W    = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_val,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic                lockup,
    output logic [WIDTH-1:0]    state_out
);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, r_adv;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             lock_q, lock_d;

    lfsr_galois_stepper #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .OUT_BITS (OUT_BITS)
    ) u_stepper (
        .r      (r_q),
        .r_next (r_adv),
        .data   (out_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            r_q     <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        lock_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // seed_load outranks start; a zero seed would freeze the LFSR
                if (seed_load) begin
                    if (seed_val == '0) begin
                        r_d    = SEED;
                        lock_d = 1'b1;
                    end else begin
                        r_d = seed_val;
                    end
                end else if (start && burst_len != '0) begin
                    state_d = RUN;
                    cnt_d   = burst_len;
                end
            end
            RUN: begin
                // abort drops the pending beat without advancing r
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    r_d   = r_adv;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign lockup    = lock_q;
    assign state_out = r_q;

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Directed self-checking bench for lfsr_galois_gen: default 1-bit instance
// plus a 4-bit-per-beat instance, vectors hand-computed from the step rule.
module tb_lfsr_galois_gen;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;

    logic        seed_load = 1'b0;
    logic [15:0] seed_val = '0;
    logic        start = 1'b0;
    logic [15:0] burst_len = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, busy, done, lockup;
    logic [0:0]  out_data;
    logic [15:0] state_out;

    logic        b_start = 1'b0;
    logic [15:0] b_burst_len = '0;
    logic        b_out_ready = 1'b0;
    logic        b_out_valid, b_busy, b_done, b_lockup;
    logic [3:0]  b_out_data;
    logic [15:0] b_state_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_galois_gen dut (
        .clk       (clk),
        .nrst      (nrst),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .lockup    (lockup),
        .state_out (state_out)
    );

    lfsr_galois_gen #(.OUT_BITS(4)) dut4 (
        .clk       (clk),
        .nrst      (nrst),
        .seed_load (1'b0),
        .seed_val  (16'h0000),
        .start     (b_start),
        .burst_len (b_burst_len),
        .abort     (1'b0),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .busy      (b_busy),
        .done      (b_done),
        .lockup    (b_lockup),
        .state_out (b_state_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #3;
        @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

    logic [6:0] rdy_pat;
    logic [3:0] exp_bits;
    int acc;

    initial begin
        do_reset();
        chk("rst_state", state_out, 16'hA2C1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lock", lockup, 0);

        // basic 3-beat burst
        start = 1; burst_len = 3; out_ready = 1;
        tick();
        start = 0;
        chk("b1_valid", out_valid, 1);
        chk("b1_busy", busy, 1);
        chk("b1_d0", out_data, 1);
        chk("b1_s0", state_out, 16'hA2C1);
        tick();
        chk("b1_d1", out_data, 0);
        chk("b1_s1", state_out, 16'hD166);
        tick();
        chk("b1_d2", out_data, 1);
        chk("b1_s2", state_out, 16'h68B3);
        tick();
        chk("b1_s3", state_out, 16'hB45F);
        chk("b1_done", done, 1);
        chk("b1_busy_end", busy, 0);
        chk("b1_valid_end", out_valid, 0);
        tick();
        chk("b1_done_pulse", done, 0);

        // 4-bit-per-beat instance
        do_reset();
        b_start = 1; b_burst_len = 1; b_out_ready = 1;
        tick();
        b_start = 0;
        chk("w4_valid", b_out_valid, 1);
        chk("w4_data", b_out_data, 4'hD);
        chk("w4_s0", b_state_out, 16'hA2C1);
        tick();
        chk("w4_s1", b_state_out, 16'hDA29);
        chk("w4_done", b_done, 1);
        chk("w4_busy", b_busy, 0);
        tick();
        chk("w4_done_pulse", b_done, 0);

        // stalled burst: ready pattern 1,0,0,1,0,1,1
        do_reset();
        rdy_pat = 7'b1101001;
        exp_bits = 4'b1101;
        acc = 0;
        start = 1; burst_len = 4; out_ready = 0;
        tick();
        start = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy_pat[i];
            chk($sformatf("st_valid%0d", i), out_valid, 1);
            chk($sformatf("st_data%0d", i), out_data, exp_bits[acc]);
            tick();
            if (rdy_pat[i]) acc++;
        end
        out_ready = 0;
        chk("st_done", done, 1);
        chk("st_busy", busy, 0);
        chk("st_state", state_out, 16'hDA29);

        // lockup guard
        tick();
        seed_load = 1; seed_val = 16'h0000;
        tick();
        seed_load = 0;
        chk("lk_state", state_out, 16'hA2C1);
        chk("lk_pulse", lockup, 1);
        tick();
        chk("lk_pulse_end", lockup, 0);
        seed_load = 1; seed_val = 16'h0001;
        tick();
        seed_load = 0;
        chk("ld_state", state_out, 16'h0001);
        chk("ld_nolock", lockup, 0);

        // abort after two accepts, then resume the sequence
        do_reset();
        start = 1; burst_len = 10; out_ready = 1;
        tick();
        start = 0;
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_state", state_out, 16'h68B3);
        tick();
        chk("ab_done2", done, 0);
        start = 1; burst_len = 1;
        tick();
        start = 0;
        chk("ab_resume_d", out_data, 1);
        chk("ab_resume_s", state_out, 16'h68B3);
        tick();
        chk("ab_resume_done", done, 1);
        chk("ab_resume_s2", state_out, 16'hB45F);

        // reset mid-burst
        start = 1; burst_len = 10; out_ready = 1;
        tick();
        start = 0;
        tick();
        nrst = 1'b0;
        #1;
        chk("mr_state", state_out, 16'hA2C1);
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_lock", lockup, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        chk("mr_done2", done, 0);

        // zero-length start is ignored
        start = 1; burst_len = 0;
        tick();
        start = 0;
        chk("z_valid", out_valid, 0);
        chk("z_busy", busy, 0);
        tick();
        chk("z_done", done, 0);
        chk("z_state", state_out, 16'hA2C1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_galois_gen.md
Name: lfsr_galois_gen

Overview:
Parametrised Galois LFSR pseudo-random generator for test-pattern and scrambler use.
- Generalises the fixed 16-bit, single-bit-per-clock generator: width, tap mask, reset seed and output bits per beat are all parameters.
- Adds runtime seed load, all-zero lockup protection, a burst length counter, and a valid/ready output stream.
- Sits between a control/CSR block (seed, start, length) and a pattern consumer (DUT stimulus, scrambler, BER checker).

Parameters:
- WIDTH, 16: LFSR register width; range 3..32.
- TAPS, 16'h0006: Galois tap mask, WIDTH bits; bit i set means bit i receives the feedback XOR.
- SEED, 16'hA2C1: reset and lockup-recovery seed, WIDTH bits, must be nonzero.
- OUT_BITS, 1: LFSR steps per output beat; range 1..WIDTH.
- LEN_W, 16: width of the burst length counter.

Ports:
- clk, input, 1: clock, rising edge.
- nrst, input, 1: asynchronous active-low reset.
- seed_load, input, 1: load seed_val; accepted only in IDLE.
- seed_val, input, WIDTH: runtime seed.
- start, input, 1: begin a burst; accepted only in IDLE.
- burst_len, input, LEN_W: number of beats in the burst; sampled on start.
- abort, input, 1: terminate the burst.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts the beat.
- out_data, output, OUT_BITS: pattern bits; bit 0 is the oldest.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse after the last beat is accepted.
- lockup, output, 1: one-cycle pulse when a zero seed is replaced by SEED.
- state_out, output, WIDTH: current LFSR register value.

Behaviour:
- Single-step function on register r:
  - nxt[WIDTH-1] = r[0]
  - nxt[i] = r[i+1] ^ (TAPS[i] & r[0]) for i < WIDTH-1
- out_data[k] = bit 0 of r after k single steps, for k = 0..OUT_BITS-1. The whole word is combinational from r.
- On an accepted beat (out_valid & out_ready), r advances OUT_BITS steps in one cycle.
- Reset (async assert, sync release):
  - r = SEED, FSM = IDLE.
  - out_valid, busy, done and lockup are 0.
  - Beat counter is 0.
- FSM states:
  - IDLE: out_valid = 0, r held.
    - seed_load: r <= seed_val at the next edge. If seed_val == 0, r <= SEED instead and lockup pulses on the following cycle.
    - start with burst_len != 0 and no seed_load: go to RUN and load cnt <= burst_len.
    - start with burst_len == 0: ignored, no done.
    - seed_load and start in the same cycle: seed_load wins, start is ignored.
  - RUN: out_valid = 1, busy = 1.
    - On an accepted beat: r advances and cnt decrements.
    - When the accepted beat has cnt == 1: go to IDLE, and done = 1 for exactly the next cycle.
    - start and seed_load are ignored.
- Stall: while out_ready = 0 in RUN, r, out_data and cnt are stable (AXI-style; valid never drops without a handshake except on abort).
- abort in RUN: go to IDLE next cycle, no done.
  - abort has priority over a handshake in the same cycle: that beat is not consumed and r is not advanced.
  - r retains its value, so a later start continues the sequence.
  - abort in IDLE has no effect.
- Latency: the first beat is valid the cycle after start is sampled. Back-to-back beats every cycle while out_ready = 1.
- Lockup: in normal running r can never reach 0 (TAPS nonzero, seed nonzero). seed_load is the only path, and it is guarded as above.
- Reset mid-burst: immediate return to reset values; no done is produced.
- state_out = r at all times.

Decomposition:
- Package lfsr_pkg:
  - typedef enum {IDLE, RUN} lfsr_state_e
  - default constants LFSR16_TAPS = 16'h0006 and LFSR16_SEED = 16'hA2C1
  - function lfsr_step(r, taps), the single Galois step
- Sub-module lfsr_galois_stepper: purely combinational, parametrised by WIDTH/TAPS/OUT_BITS. Produces r_next (OUT_BITS steps ahead) and the out_data word via an unrolled lfsr_step chain.
- lfsr_galois_gen holds the register, FSM, counter and handshake.

Test Plan:
- Defaults, after reset, start with burst_len = 3 and out_ready = 1 -> out_data = 1, 0, 1 on consecutive cycles; state_out goes A2C1 -> D166 -> 68B3 -> B45F; done pulses once; busy drops.
- OUT_BITS = 4, reset, start with burst_len = 1 -> out_data = 4'hD; state_out = DA29 after acceptance; done pulses once.
- Defaults, burst_len = 4 with out_ready toggling 1,0,0,1,0,1,1 -> exactly 4 accepted beats, bits 1,0,1,1; out_data is stable across stalls; done follows the 4th accept.
- In IDLE, seed_load with seed_val = 0 -> state_out = A2C1 and one lockup pulse. Then seed_load with seed_val = 16'h0001 -> state_out = 0001 and no lockup.
- Start burst_len = 10, abort after 2 accepts while out_ready = 1 -> busy drops and no done. A new start with burst_len = 1 outputs bit 1, the 3rd bit of the sequence.
- Assert nrst mid-burst, and separately start with burst_len = 0 -> after reset all outputs are 0 and state_out = A2C1. The burst_len = 0 start leaves FSM in IDLE with no out_valid and no done.
